// File: rtl/uart_cmd_responder.sv
// Command responder on the fabric side of the UART: parses 0xA5-framed requests from
// the RX FIFO, runs ECHO/WRITE/READ against a small register file, answers with 0x5A frames.
module uart_cmd_responder #(
   parameter int FIFO_WIDTH = 8,
   parameter int MAX_LEN    = 16,
   parameter int REG_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] rx_rd_data,
   input  logic                  rx_valid,
   output logic                  rx_rd,
   output logic [FIFO_WIDTH-1:0] tx_wr_data,
   output logic                  tx_wr,
   input  logic                  tx_full,
   output logic                  busy,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic [2:0]            state_dbg
);

   // RX: a byte moves on every cycle with rx_valid && rx_rd; rx_valid low just holds state.
   // TX: tx_wr is raised only while tx_full is low, and each raised cycle moves one byte.

   localparam int IDX_W = $clog2(MAX_LEN + 1);
   localparam int PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int AW    = $clog2(REG_DEPTH);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef logic [FIFO_WIDTH-1:0] byte_t;

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_CMD  = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_CHK  = 3'd4,
      S_EXEC = 3'd5,
      S_TX   = 3'd6
   } state_t;

   state_t state, state_nxt;

   byte_t            cmd_q;
   byte_t            len_q;
   byte_t            chk_q;
   byte_t            status_q;
   byte_t            rlen_q;
   byte_t            tx_chk_q;
   logic             chk_bad_q;
   logic [IDX_W-1:0] idx_q;
   logic [8:0]       pos_q;
   logic             frame_ok_q;
   logic             frame_err_q;
   byte_t            pay_q [2**PW];
   byte_t            reg_q [REG_DEPTH];

   logic             rx_fire;
   logic             data_last;
   logic             len_big;
   logic             cmd_known;
   logic             len_bad;
   byte_t            status_c;
   byte_t            rlen_c;
   logic             tx_last;
   logic [PW-1:0]    pay_idx;
   byte_t            tx_byte;

   assign rx_fire   = rx_valid && rx_rd;
   assign data_last = (({{(9-IDX_W){1'b0}}, idx_q} + 9'd1) == {1'b0, len_q});
   assign tx_last   = (pos_q == ({1'b0, rlen_q} + 9'd3));
   assign pay_idx   = PW'(pos_q - 9'd3);
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign state_dbg = state;

   // Status priority: oversize length, bad checksum, unknown command, wrong length.
   always_comb begin
      len_big   = (len_q > MAX_LEN_B);
      cmd_known = (cmd_q == 8'h01) || (cmd_q == 8'h02) || (cmd_q == 8'h03);
      len_bad   = ((cmd_q == 8'h02) && (len_q != 8'd2)) ||
                  ((cmd_q == 8'h03) && (len_q != 8'd1));
      status_c  = 8'h00;
      rlen_c    = 8'h00;
      if (len_big) begin
         status_c = 8'h03;
      end else if (chk_bad_q) begin
         status_c = 8'h01;
      end else if (!cmd_known) begin
         status_c = 8'h02;
      end else if (len_bad) begin
         status_c = 8'h04;
      end else begin
         case (cmd_q)
            8'h01:   rlen_c = len_q;
            8'h03:   rlen_c = 8'h01;
            default: rlen_c = 8'h00;
         endcase
      end
   end

   // Response byte at position pos_q: header, status, length, payload, checksum.
   always_comb begin
      tx_byte = 8'h00;
      if (pos_q == 9'd0) begin
         tx_byte = 8'h5A;
      end else if (pos_q == 9'd1) begin
         tx_byte = status_q;
      end else if (pos_q == 9'd2) begin
         tx_byte = rlen_q;
      end else if (tx_last) begin
         tx_byte = tx_chk_q;
      end else if (cmd_q == 8'h03) begin
         tx_byte = reg_q[pay_q[0][AW-1:0]];
      end else begin
         tx_byte = pay_q[pay_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rx_rd      = 1'b0;
      busy       = 1'b1;
      tx_wr      = 1'b0;
      tx_wr_data = '0;
      case (state)
         S_SYNC: begin
            busy  = 1'b0;
            rx_rd = 1'b1;
            if (rx_valid && (rx_rd_data == 8'hA5)) state_nxt = S_CMD;
         end
         S_CMD: begin
            rx_rd = 1'b1;
            if (rx_valid) state_nxt = S_LEN;
         end
         S_LEN: begin
            rx_rd = 1'b1;
            if (rx_valid) begin
               if (rx_rd_data > MAX_LEN_B)     state_nxt = S_EXEC;
               else if (rx_rd_data == 8'h00)  state_nxt = S_CHK;
               else                           state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            rx_rd = 1'b1;
            if (rx_valid && data_last) state_nxt = S_CHK;
         end
         S_CHK: begin
            rx_rd = 1'b1;
            if (rx_valid) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            state_nxt = S_TX;
         end
         S_TX: begin
            tx_wr      = !tx_full;
            tx_wr_data = tx_byte;
            if (!tx_full && tx_last) state_nxt = S_SYNC;
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q       <= '0;
         len_q       <= '0;
         chk_q       <= '0;
         status_q    <= '0;
         rlen_q      <= '0;
         tx_chk_q    <= '0;
         chk_bad_q   <= 1'b0;
         idx_q       <= '0;
         pos_q       <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < 2**PW; i++) pay_q[i] <= '0;
         for (int i = 0; i < REG_DEPTH; i++) reg_q[i] <= '0;
      end else begin
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state)
            S_CMD: begin
               if (rx_fire) begin
                  cmd_q     <= rx_rd_data;
                  chk_q     <= rx_rd_data;
                  chk_bad_q <= 1'b0;
               end
            end
            S_LEN: begin
               if (rx_fire) begin
                  len_q <= rx_rd_data;
                  chk_q <= chk_q ^ rx_rd_data;
                  idx_q <= '0;
               end
            end
            S_DATA: begin
               if (rx_fire) begin
                  pay_q[idx_q[PW-1:0]] <= rx_rd_data;
                  chk_q                <= chk_q ^ rx_rd_data;
                  idx_q                <= idx_q + 1'b1;
               end
            end
            S_CHK: begin
               if (rx_fire) chk_bad_q <= (rx_rd_data != chk_q);
            end
            S_EXEC: begin
               status_q <= status_c;
               rlen_q   <= rlen_c;
               pos_q    <= '0;
               tx_chk_q <= '0;
               if ((status_c == 8'h00) && (cmd_q == 8'h02)) begin
                  reg_q[pay_q[0][AW-1:0]] <= pay_q[1];
               end
            end
            S_TX: begin
               if (tx_wr) begin
                  pos_q <= pos_q + 9'd1;
                  // The running response checksum covers everything between header and RCHK.
                  if ((pos_q != 9'd0) && !tx_last) tx_chk_q <= tx_chk_q ^ tx_byte;
                  if (tx_last) begin
                     frame_ok_q  <= (status_q == 8'h00);
                     frame_err_q <= (status_q != 8'h00);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: directed frame table, backpressure and reset sequences,
// then random frames scored against a frame-level reference model.
module tb_uart_cmd_responder;

   localparam int MAX_LEN   = 16;
   localparam int REG_DEPTH = 16;

   logic       clk;
   logic       rst;
   logic [7:0] rx_rd_data;
   logic       rx_valid;
   logic       rx_rd;
   logic [7:0] tx_wr_data;
   logic       tx_wr;
   logic       tx_full;
   logic       busy;
   logic       frame_ok;
   logic       frame_err;
   logic [2:0] state_dbg;

   uart_cmd_responder #(.FIFO_WIDTH(8), .MAX_LEN(MAX_LEN), .REG_DEPTH(REG_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_rd_data (rx_rd_data),
      .rx_valid   (rx_valid),
      .rx_rd      (rx_rd),
      .tx_wr_data (tx_wr_data),
      .tx_wr      (tx_wr),
      .tx_full    (tx_full),
      .busy       (busy),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .state_dbg  (state_dbg)
   );

   typedef struct {
      int          req_n;
      logic [95:0] req;
      int          rsp_n;
      logic [63:0] rsp;
      bit          ok;
   } vec_t;

   int         checks;
   int         errors;
   int         tx_count;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   bit         exp_last_q[$];
   bit         exp_ok_q[$];
   logic [7:0] model_regs [REG_DEPTH];
   bit         hold_rx;
   bit         bubble_en;
   bit         bp_en;
   bit         force_full;
   bit         in_resp;
   bit         pend_flag;
   vec_t       vecs [13];

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // RX driver: presents the head of rx_q, pops it once the DUT has taken it.
   initial begin
      bit         pending;
      logic [7:0] tmp;
      rx_valid   = 1'b0;
      rx_rd_data = 8'h00;
      pending    = 1'b0;
      forever begin
         @(negedge clk);
         if (pending && (rx_q.size() > 0)) tmp = rx_q.pop_front();
         if (rst || hold_rx || (rx_q.size() == 0) || (bubble_en && ($urandom_range(0, 3) == 0))) begin
            rx_valid   = 1'b0;
            rx_rd_data = 8'h00;
         end else begin
            rx_valid   = 1'b1;
            rx_rd_data = rx_q[0];
         end
         pending = rx_valid && rx_rd;
      end
   end

   // TX backpressure driver
   initial begin
      tx_full = 1'b0;
      forever begin
         @(negedge clk);
         tx_full = force_full || (bp_en && ($urandom_range(0, 3) == 0));
      end
   end

   // Scoreboard / monitor on the TX side and the completion pulses.
   initial begin
      logic [7:0] eb;
      bit         el;
      bit         eok;
      in_resp   = 1'b0;
      pend_flag = 1'b0;
      tx_count  = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            in_resp   = 1'b0;
            pend_flag = 1'b0;
         end else begin
            if (pend_flag) begin
               pend_flag = 1'b0;
               if (exp_ok_q.size() > 0) begin
                  eok = exp_ok_q.pop_front();
                  chk("frame_ok", frame_ok, eok);
                  chk("frame_err", frame_err, !eok);
               end
            end else if (frame_ok || frame_err) begin
               chk("spurious_pulse", {frame_ok, frame_err}, 0);
            end
            if (tx_wr) begin
               tx_count++;
               chk("wr_while_full", tx_full, 0);
               chk("rx_rd_in_tx", rx_rd, 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_tx actual=%0h required=none t=%0t", tx_wr_data, $time);
               end else begin
                  eb = exp_q.pop_front();
                  el = exp_last_q.pop_front();
                  chk("tx_byte", tx_wr_data, eb);
                  in_resp = !el;
                  if (el) pend_flag = 1'b1;
               end
            end else if (in_resp && !tx_full) begin
               chk("tx_gap", tx_wr, 1);
            end
         end
      end
   end

   task automatic push_exp(input logic [7:0] q[$], input bit ok);
      for (int i = 0; i < q.size(); i++) begin
         exp_q.push_back(q[i]);
         exp_last_q.push_back(i == q.size() - 1);
      end
      exp_ok_q.push_back(ok);
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (((rx_q.size() != 0) || (exp_q.size() != 0) || (exp_ok_q.size() != 0)) && (n < max_cycles)) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("drain_timeout", (n >= max_cycles), 0);
      if (n >= max_cycles) begin
         rx_q.delete();
         exp_q.delete();
         exp_last_q.delete();
         exp_ok_q.delete();
      end
   endtask

   task automatic send_vec(input vec_t v);
      logic [7:0] r[$];
      r = {};
      for (int i = 0; i < v.req_n; i++) rx_q.push_back(v.req[8*(v.req_n-1-i) +: 8]);
      for (int i = 0; i < v.rsp_n; i++) r.push_back(v.rsp[8*(v.rsp_n-1-i) +: 8]);
      push_exp(r, v.ok);
      wait_drain(500);
   endtask

   // Reference model: whole-frame rules, response appended to the scoreboard.
   task automatic model_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] pl[$], input logic [7:0] chk_b);
      logic [7:0] x;
      logic [7:0] st;
      logic [7:0] rsp[$];
      logic [7:0] full[$];
      x = cmd ^ len;
      foreach (pl[i]) x ^= pl[i];
      if (len > MAX_LEN)                                     st = 8'h03;
      else if (chk_b != x)                                   st = 8'h01;
      else if (!(cmd inside {8'h01, 8'h02, 8'h03}))          st = 8'h02;
      else if ((cmd == 8'h02 && len != 2) || (cmd == 8'h03 && len != 1)) st = 8'h04;
      else                                                   st = 8'h00;
      rsp = {};
      if (st == 8'h00) begin
         if (cmd == 8'h01) rsp = pl;
         else if (cmd == 8'h02) model_regs[pl[0] % REG_DEPTH] = pl[1];
         else rsp.push_back(model_regs[pl[0] % REG_DEPTH]);
      end
      full = {8'h5A, st, 8'(rsp.size())};
      x = st ^ 8'(rsp.size());
      foreach (rsp[i]) begin
         full.push_back(rsp[i]);
         x ^= rsp[i];
      end
      full.push_back(x);
      push_exp(full, st == 8'h00);
   endtask

   task automatic gen_random(input int nframes);
      for (int f = 0; f < nframes; f++) begin
         logic [7:0] cmd;
         logic [7:0] len;
         logic [7:0] c;
         logic [7:0] g;
         logic [7:0] pl[$];
         int         kind;
         int         ng;
         pl   = {};
         kind = $urandom_range(0, 7);
         ng   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         for (int i = 0; i < ng; i++) begin
            do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
            rx_q.push_back(g);
         end
         case (kind)
            2: begin cmd = 8'h02; len = 8'd2; end
            3: begin cmd = 8'h03; len = 8'd1; end
            5: begin
               do cmd = 8'($urandom_range(0, 255)); while (cmd inside {8'h01, 8'h02, 8'h03});
               len = 8'($urandom_range(0, 4));
            end
            6: begin
               cmd = 8'($urandom_range(2, 3));
               do len = 8'($urandom_range(0, 5)); while (len == ((cmd == 8'h02) ? 8'd2 : 8'd1));
            end
            7: begin
               cmd = 8'($urandom_range(1, 3));
               len = 8'($urandom_range(MAX_LEN + 1, 255));
            end
            default: begin cmd = 8'h01; len = 8'($urandom_range(0, MAX_LEN)); end
         endcase
         c = cmd ^ len;
         if (len <= MAX_LEN) begin
            for (int i = 0; i < len; i++) begin
               pl.push_back(8'($urandom_range(0, 255)));
               c ^= pl[i];
            end
         end
         if (kind == 4) c ^= 8'($urandom_range(1, 255));
         rx_q.push_back(8'hA5);
         rx_q.push_back(cmd);
         rx_q.push_back(len);
         if (len <= MAX_LEN) begin
            foreach (pl[i]) rx_q.push_back(pl[i]);
            rx_q.push_back(c);
         end
         model_frame(cmd, len, pl, c);
      end
   endtask

   initial begin
      int         n;
      int         base;
      logic [7:0] r[$];
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      hold_rx    = 1'b0;
      bubble_en  = 1'b0;
      bp_en      = 1'b0;
      force_full = 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) model_regs[i] = 8'h00;

      vecs[0]  = '{6, 96'hA5_01_02_11_22_30, 6, 64'h5A_00_02_11_22_31, 1'b1};
      vecs[1]  = '{6, 96'hA5_02_02_03_7E_7D, 4, 64'h5A_00_00_00, 1'b1};
      vecs[2]  = '{5, 96'hA5_03_01_03_01, 5, 64'h5A_00_01_7E_7F, 1'b1};
      vecs[3]  = '{6, 96'hA5_01_02_11_22_31, 4, 64'h5A_01_00_01, 1'b0};
      vecs[4]  = '{4, 96'hA5_09_00_09, 4, 64'h5A_02_00_02, 1'b0};
      vecs[5]  = '{6, 96'hA5_03_02_03_04_06, 4, 64'h5A_04_00_04, 1'b0};
      vecs[6]  = '{3, 96'hA5_01_20, 4, 64'h5A_03_00_03, 1'b0};
      vecs[7]  = '{9, 96'hFF_00_5A_A5_01_02_11_22_30, 6, 64'h5A_00_02_11_22_31, 1'b1};
      vecs[8]  = '{4, 96'hA5_01_00_01, 4, 64'h5A_00_00_00, 1'b1};
      vecs[9]  = '{5, 96'hA5_02_01_05_06, 4, 64'h5A_04_00_04, 1'b0};
      vecs[10] = '{4, 96'hA5_09_00_00, 4, 64'h5A_01_00_01, 1'b0};
      vecs[11] = '{3, 96'hA5_01_11, 4, 64'h5A_03_00_03, 1'b0};
      vecs[12] = '{5, 96'hA5_03_01_03_01, 5, 64'h5A_00_01_7E_7F, 1'b1};

      repeat (3) @(posedge clk);
      #2;
      chk("rst_rx_rd", rx_rd, 1);
      chk("rst_tx_wr", tx_wr, 0);
      chk("rst_tx_data", tx_wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_ok", frame_ok, 0);
      chk("rst_frame_err", frame_err, 0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      for (int i = 0; i < 13; i++) send_vec(vecs[i]);

      // Backpressure: five full cycles in the middle of a 4-byte ECHO response.
      base = tx_count;
      rx_q = {8'hA5, 8'h01, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h45};
      r    = {8'h5A, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
      push_exp(r, 1'b1);
      n = 0;
      while ((tx_count < base + 3) && (n < 200)) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("bp_start_timeout", (n >= 200), 0);
      force_full = 1'b1;
      @(negedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_no_wr", tx_wr, 0);
         chk("stall_busy", busy, 1);
         @(negedge clk);
         #1;
      end
      force_full = 1'b0;
      wait_drain(500);

      // Reset in the middle of a payload, then read back a register written earlier.
      rx_q = {8'hA5, 8'h01, 8'h05, 8'h11, 8'h22};
      n = 0;
      while ((rx_q.size() != 0) && (n < 200)) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("partial_timeout", (n >= 200), 0);
      @(posedge clk);
      #2;
      chk("mid_frame_busy", busy, 1);
      hold_rx = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rx_q.delete();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rx_rd", rx_rd, 1);
      chk("mid_rst_tx_wr", tx_wr, 0);
      rst     = 1'b0;
      hold_rx = 1'b0;
      @(posedge clk);
      #2;
      send_vec('{5, 96'hA5_03_01_03_01, 5, 64'h5A_00_01_00_01, 1'b1});

      // Random frames with RX bubbles and TX backpressure against the model.
      bubble_en = 1'b1;
      bp_en     = 1'b1;
      gen_random(40);
      wait_drain(30000);
      bubble_en = 1'b0;
      bp_en     = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("idle_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Host-facing command responder on the fabric side of the UART block. It drains received bytes from the UART receive FIFO, parses framed commands, and executes them against a small internal register file. It writes framed responses back into the UART transmit FIFO. It is the far end of the byte-stream interface the UART exposes: it consumes RX data and produces TX data.

## Interface
- FIFO_WIDTH, definitions_pkg value (8): byte width of RX/TX data.
- MAX_LEN, 16: maximum payload bytes per frame (1..255).
- REG_DEPTH, 16: register file entries, 8 bits each (power of two, ≤256).
- clk  in  1: single clock.
- rst  in  1: synchronous, active-high reset.
- rx_rd_data  in  FIFO_WIDTH: head byte of the UART RX FIFO.
- rx_valid  in  1: rx_rd_data holds a valid byte.
- rx_rd  out  1: pop request. A byte is consumed on any cycle where rx_valid && rx_rd.
- tx_wr_data  out  FIFO_WIDTH: byte to the UART TX FIFO.
- tx_wr  out  1: write strobe. Asserted only when tx_full=0. One byte per asserted cycle.
- tx_full  in  1: TX FIFO full.
- busy  out  1: high in every state except S_SYNC.
- frame_ok  out  1: one-cycle pulse when a response with status 0x00 finishes.
- frame_err  out  1: one-cycle pulse when a response with nonzero status finishes.

## Operation
**Request frame:** 0xA5, CMD, LEN, LEN payload bytes, CHK.
- CHK = XOR of CMD, LEN and all payload bytes.

**Response frame:** 0x5A, STATUS, RLEN, RLEN bytes, RCHK.
- RCHK = XOR of STATUS, RLEN and all response payload bytes.

**Commands:**
- 0x01 ECHO: response payload equals the request payload (RLEN=LEN).
- 0x02 WRITE: LEN must be 2. Payload is {addr, data}. Writes reg[addr mod REG_DEPTH] and returns RLEN=0.
- 0x03 READ: LEN must be 1. Payload is {addr}. Returns RLEN=1 with reg[addr mod REG_DEPTH].

**STATUS codes:**
- 0x00: OK.
- 0x01: checksum mismatch.
- 0x02: unknown CMD.
- 0x03: LEN > MAX_LEN.
- 0x04: LEN wrong for WRITE or READ.
- Every error response has RLEN=0. No register side effects occur on any error.

**FSM:**
- S_SYNC: consume bytes. Discard any byte ≠ 0xA5; on 0xA5 go to S_CMD.
- S_CMD: latch CMD, seed the running checksum with it.
- S_LEN: latch LEN.
  - LEN > MAX_LEN: go to S_EXEC with status 0x03. Remaining request bytes are not consumed; they are later hunted through in S_SYNC.
  - LEN = 0: go to S_CHK.
  - Otherwise: go to S_DATA.
- S_DATA: store each byte in payload buffer[idx]. After LEN bytes go to S_CHK.
- S_CHK: compare the received byte with the running XOR, then go to S_EXEC.
- S_EXEC: one cycle, no RX consumption. Status is resolved in priority order: 0x03, then 0x01, then 0x02, then 0x04. On OK, a WRITE is performed here. Go to S_TX.
- S_TX: emit the response bytes in order, one per cycle while tx_full=0. Stall without losing a byte while tx_full=1. After RCHK, pulse frame_ok or frame_err and go to S_SYNC.

**Other behaviour:**
- rx_rd = 1 in S_SYNC, S_CMD, S_LEN, S_DATA and S_CHK; 0 in S_EXEC and S_TX.
- Arithmetic: the checksum is 8-bit XOR. The payload index counter is ceil(log2(MAX_LEN+1)) bits.

## Timing
- Reset: state S_SYNC, all registers 0. Outputs: rx_rd=1, tx_wr=0, tx_wr_data=0, busy=0, frame_ok=0, frame_err=0.
- Reset mid-frame or mid-response aborts immediately with no partial completion. The TX FIFO may hold a truncated response; that is acceptable.
- RX throughput: 1 byte/cycle when rx_valid stays high. Bubbles (rx_valid=0) hold state.
- Latency:
  - Byte accepted in S_CHK → S_EXEC on the next cycle.
  - First tx_wr (0x5A) one cycle after S_EXEC, if tx_full=0.
  - Response of N total bytes with no stalls: N consecutive tx_wr cycles.
- frame_ok/frame_err are asserted in the cycle after the RCHK write and are never both high.
- A READ of an address written by the immediately preceding frame returns the new data.

## Test plan
- ECHO: A5 01 02 11 22 30 → TX 5A 00 02 11 22 31; frame_ok pulse; rx_rd low during response.
- WRITE then READ: A5 02 02 03 7E 7D → 5A 00 00 00. Then A5 03 01 03 01 → 5A 00 01 7E 7F.
- Errors:
  - ECHO with bad CHK (A5 01 02 11 22 31) → 5A 01 00 01, frame_err.
  - Unknown CMD (A5 09 00 09) → 5A 02 00 02.
  - READ with LEN=2 → STATUS 0x04.
  - LEN=0x20 → 5A 03 00 03.
- Sync hunt: garbage FF 00 5A preceding a valid ECHO frame → the garbage is dropped and the correct ECHO response is produced.
- Backpressure: hold tx_full=1 for 5 cycles mid-response → tx_wr stays 0 during the stall. Byte order and values are unchanged, with no duplicates or drops.
- Reset mid-S_DATA, then send a full READ of addr 3 → returns 00 (register file cleared). The FSM restarts in S_SYNC.
